// File: rtl/memory_test_fabric_if.sv
// Wishbone slave bus for the user-area memory fabric.
// The management core drives the master side; the fabric is the slave.
interface memory_test_fabric_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [3:0]  wb_sel_i;
  logic [23:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic        wb_ack_o;
  logic [31:0] wb_dat_o;

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    output wb_ack_o, wb_dat_o
  );

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    input  wb_ack_o, wb_dat_o
  );
endinterface

// File: rtl/memory_test_fabric.sv
// Wishbone-slave memory fabric: two per-core SRAM banks, a video SRAM and a test-status
// register driving two user GPIOs. Unmapped accesses always ack with UnmappedVal.
module memory_test_fabric #(
  parameter int unsigned CoreWords   = 256,
  parameter int unsigned VideoWords  = 512,
  parameter logic [31:0] UnmappedVal = 32'hFFFF_FFFF
) (
  input  logic                 clock,
  input  logic                 resetb,
  memory_test_fabric_if.slave  bus,
  output logic                 success_o,
  output logic                 next_test_o,
  output logic [1:0]           io_oeb_o
);

  localparam int unsigned CoreAw  = $clog2(CoreWords);
  localparam int unsigned VideoAw = $clog2(VideoWords);

  logic              ack_q;
  logic [31:0]       dat_q;
  logic [1:0]        status_q;

  logic              req;
  logic              wr_en;
  logic [3:0]        region;
  logic [17:0]       word_idx;
  logic [CoreAw-1:0] core_idx;
  logic [VideoAw-1:0] video_idx;
  logic              hit_core0;
  logic              hit_core1;
  logic              hit_video;
  logic              hit_status;
  logic [31:0]       rd_data;

  logic [31:0] core0_mem [CoreWords];
  logic [31:0] core1_mem [CoreWords];
  logic [31:0] video_mem [VideoWords];

  // The byte offset within a word has no meaning here; reads are always full words.
  logic unused_adr;
  assign unused_adr = ^bus.wb_adr_i[1:0];

  assign req       = bus.wb_cyc_i & bus.wb_stb_i & ~ack_q;
  assign region    = bus.wb_adr_i[23:20];
  assign word_idx  = bus.wb_adr_i[19:2];
  assign core_idx  = word_idx[CoreAw-1:0];
  assign video_idx = word_idx[VideoAw-1:0];

  assign hit_core0  = (region == 4'h0) && (32'(word_idx) < CoreWords);
  assign hit_core1  = (region == 4'h1) && (32'(word_idx) < CoreWords);
  assign hit_video  = (region == 4'h2) && (32'(word_idx) < VideoWords);
  assign hit_status = (region == 4'h3) && (word_idx == 18'd0);

  // Reset dominates a request sampled in the same cycle.
  assign wr_en = req & bus.wb_we_i & resetb;

  // SRAM banks carry no reset; contents are undefined until written.
  always_ff @(posedge clock) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_en && bus.wb_sel_i[b]) begin
        if (hit_core0) core0_mem[core_idx][8*b +: 8] <= bus.wb_dat_i[8*b +: 8];
        if (hit_core1) core1_mem[core_idx][8*b +: 8] <= bus.wb_dat_i[8*b +: 8];
        if (hit_video) video_mem[video_idx][8*b +: 8] <= bus.wb_dat_i[8*b +: 8];
      end
    end
  end

  always_comb begin
    rd_data = UnmappedVal;
    if (hit_core0) begin
      rd_data = core0_mem[core_idx];
    end else if (hit_core1) begin
      rd_data = core1_mem[core_idx];
    end else if (hit_video) begin
      rd_data = video_mem[video_idx];
    end else if (hit_status) begin
      rd_data = {30'd0, status_q};
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      status_q <= 2'b00;
    end else begin
      ack_q <= req;
      dat_q <= (req && !bus.wb_we_i) ? rd_data : '0;
      if (req && bus.wb_we_i && hit_status && bus.wb_sel_i[0]) begin
        status_q <= bus.wb_dat_i[1:0];
      end
    end
  end

  assign bus.wb_ack_o = ack_q;
  assign bus.wb_dat_o = dat_q;
  assign success_o    = status_q[0];
  assign next_test_o  = status_q[1];
  assign io_oeb_o     = 2'b00;

endmodule

// File: tb/tb_memory_test_fabric.sv
// Self-checking bench for memory_test_fabric: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a word-level model of the memory map.
module tb_memory_test_fabric;

  localparam int unsigned CW = 256;
  localparam int unsigned VW = 512;

  logic       clock;
  logic       resetb;
  logic       success_o;
  logic       next_test_o;
  logic [1:0] io_oeb_o;

  memory_test_fabric_if bus ();

  memory_test_fabric #(
    .CoreWords  (CW),
    .VideoWords (VW),
    .UnmappedVal(32'hFFFF_FFFF)
  ) dut (
    .clock      (clock),
    .resetb     (resetb),
    .bus        (bus),
    .success_o  (success_o),
    .next_test_o(next_test_o),
    .io_oeb_o   (io_oeb_o)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: plain word arrays per bank plus the two status bits.
  logic [31:0] m_c0 [CW];
  logic [31:0] m_c1 [CW];
  logic [31:0] m_vid[VW];
  logic [1:0]  exp_st;
  logic        exp_ack;
  logic        exp_rd;
  logic [31:0] exp_dat;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] sel,
                                        input logic [31:0] d);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic int unsigned reg_of(input logic [23:0] a);
    return int'(a) / 32'h10_0000;
  endfunction

  function automatic int unsigned word_of(input logic [23:0] a);
    return (int'(a) % 32'h10_0000) / 4;
  endfunction

  function automatic logic [31:0] model_read(input logic [23:0] a);
    int unsigned r;
    int unsigned w;
    r = reg_of(a);
    w = word_of(a);
    if (r == 0 && w < CW) return m_c0[w];
    if (r == 1 && w < CW) return m_c1[w];
    if (r == 2 && w < VW) return m_vid[w];
    if (r == 3 && w == 0) return {30'd0, exp_st};
    return 32'hFFFF_FFFF;
  endfunction

  logic        m_req;
  int unsigned m_r;
  int unsigned m_w;
  assign m_req = bus.wb_cyc_i & bus.wb_stb_i & ~exp_ack;
  assign m_r   = reg_of(bus.wb_adr_i);
  assign m_w   = word_of(bus.wb_adr_i);

  always @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      exp_ack <= 1'b0;
      exp_rd  <= 1'b0;
      exp_dat <= '0;
      exp_st  <= 2'b00;
    end else begin
      exp_ack <= m_req;
      exp_rd  <= m_req & ~bus.wb_we_i;
      exp_dat <= (m_req && !bus.wb_we_i) ? model_read(bus.wb_adr_i) : 32'd0;
      if (m_req && bus.wb_we_i) begin
        if (m_r == 0 && m_w < CW) m_c0[m_w] <= merge(m_c0[m_w], bus.wb_sel_i, bus.wb_dat_i);
        if (m_r == 1 && m_w < CW) m_c1[m_w] <= merge(m_c1[m_w], bus.wb_sel_i, bus.wb_dat_i);
        if (m_r == 2 && m_w < VW) m_vid[m_w] <= merge(m_vid[m_w], bus.wb_sel_i, bus.wb_dat_i);
        if (m_r == 3 && m_w == 0 && bus.wb_sel_i[0]) exp_st <= bus.wb_dat_i[1:0];
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clock) begin
    check("ack", {31'd0, bus.wb_ack_o}, {31'd0, exp_ack});
    if (exp_ack && exp_rd) check("rdata", bus.wb_dat_o, exp_dat);
    else if (!exp_ack) check("dat_idle", bus.wb_dat_o, 32'd0);
    check("success", {31'd0, success_o}, {31'd0, exp_st[0]});
    check("next_test", {31'd0, next_test_o}, {31'd0, exp_st[1]});
    check("oeb", {30'd0, io_oeb_o}, 32'd0);
  end

  task automatic xfer(input logic we, input logic [23:0] adr, input logic [3:0] sel,
                      input logic [31:0] dat, output logic [31:0] rdata);
    int n;
    @(negedge clock);
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = we;
    bus.wb_adr_i = adr;
    bus.wb_sel_i = sel;
    bus.wb_dat_i = dat;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!bus.wb_ack_o && n < 8);
    check("ack_latency", 32'(n), 32'd1);
    rdata = bus.wb_dat_o;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
  endtask

  task automatic wr(input logic [23:0] adr, input logic [3:0] sel, input logic [31:0] dat);
    logic [31:0] unused;
    xfer(1'b1, adr, sel, dat, unused);
  endtask

  task automatic rd_expect(input string name, input logic [23:0] adr, input logic [31:0] exp);
    logic [31:0] got;
    xfer(1'b0, adr, 4'hF, 32'd0, got);
    check(name, got, exp);
  endtask

  initial begin
    logic [23:0] adr;
    logic [31:0] got;
    int unsigned sel_r;
    int unsigned w;

    // Reset asserted with a pending status write: reset must dominate.
    resetb       = 1'b0;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = 1'b1;
    bus.wb_sel_i = 4'hF;
    bus.wb_adr_i = 24'h30_0000;
    bus.wb_dat_i = 32'h3;
    repeat (4) @(negedge clock);
    check("rst_ack", {31'd0, bus.wb_ack_o}, 32'd0);
    check("rst_dat", bus.wb_dat_o, 32'd0);
    check("rst_success", {31'd0, success_o}, 32'd0);
    check("rst_next_test", {31'd0, next_test_o}, 32'd0);
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    resetb       = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("no_spurious_ack", {31'd0, bus.wb_ack_o}, 32'd0);
    end

    // Bank independence.
    wr(24'h00_0010, 4'hF, 32'hDEAD_BEEF);
    wr(24'h10_0010, 4'hF, 32'hCAFE_F00D);
    rd_expect("core0_rd", 24'h00_0010, 32'hDEAD_BEEF);
    rd_expect("core1_rd", 24'h10_0010, 32'hCAFE_F00D);

    // Video halves and the last word of each half.
    wr(24'h20_0000, 4'hF, 32'h1234_5678);
    wr(24'h20_0000 + 24'(4 * (VW / 2)), 4'hF, 32'h9ABC_DEF0);
    wr(24'h20_0000 + 24'(4 * (VW / 2) - 4), 4'hF, 32'hA5A5_0001);
    wr(24'h20_0000 + 24'(4 * VW - 4), 4'hF, 32'h5A5A_0002);
    rd_expect("video_lo", 24'h20_0000, 32'h1234_5678);
    rd_expect("video_hi", 24'h20_0000 + 24'(4 * (VW / 2)), 32'h9ABC_DEF0);
    rd_expect("video_lo_last", 24'h20_0000 + 24'(4 * (VW / 2) - 4), 32'hA5A5_0001);
    rd_expect("video_hi_last", 24'h20_0000 + 24'(4 * VW - 4), 32'h5A5A_0002);

    // Byte-lane merging and sel=0.
    wr(24'h00_0020, 4'hF, 32'hFFFF_FFFF);
    wr(24'h00_0020, 4'b0001, 32'h0000_00AA);
    wr(24'h00_0020, 4'b1100, 32'h5555_0000);
    rd_expect("lane_merge", 24'h00_0020, 32'h5555_FFAA);
    wr(24'h00_0030, 4'hF, 32'h1357_9BDF);
    wr(24'h00_0030, 4'b0000, 32'h0000_0000);
    rd_expect("sel_zero", 24'h00_0030, 32'h1357_9BDF);

    // Unmapped reads and writes.
    wr(24'h00_0000, 4'hF, 32'h1111_1111);
    wr(24'h00_0000 + 24'(4 * CW), 4'hF, 32'h2222_2222);
    wr(24'h40_0000, 4'hF, 32'h3333_3333);
    wr(24'h30_0004, 4'hF, 32'h3);
    rd_expect("unmap_region", 24'h40_0000, 32'hFFFF_FFFF);
    rd_expect("unmap_core", 24'h00_0000 + 24'(4 * CW), 32'hFFFF_FFFF);
    rd_expect("unmap_status", 24'h30_0004, 32'hFFFF_FFFF);
    rd_expect("no_alias", 24'h00_0000, 32'h1111_1111);
    check("unmap_st_write", {30'd0, next_test_o, success_o}, 32'd0);

    // Status register sequencing.
    wr(24'h30_0000, 4'hF, 32'h2);
    check("st_next1", {31'd0, next_test_o}, 32'd1);
    wr(24'h30_0000, 4'hF, 32'h0);
    check("st_next0", {31'd0, next_test_o}, 32'd0);
    wr(24'h30_0000, 4'hF, 32'h3);
    check("st_success", {31'd0, success_o}, 32'd1);
    check("st_next", {31'd0, next_test_o}, 32'd1);
    rd_expect("st_read", 24'h30_0000, 32'h0000_0003);

    // Fill every bank so all later reads are defined.
    for (int i = 0; i < int'(CW); i++) begin
      wr(24'h00_0000 + 24'(4 * i), 4'hF, $urandom);
      wr(24'h10_0000 + 24'(4 * i), 4'hF, $urandom);
    end
    for (int i = 0; i < int'(VW); i++) wr(24'h20_0000 + 24'(4 * i), 4'hF, $urandom);

    // Random traffic; the compare process checks every ack against the model.
    for (int t = 0; t < 600; t++) begin
      sel_r = $urandom_range(0, 7);
      case (sel_r)
        0, 1:    adr = {4'h0, 18'($urandom_range(0, CW - 1)), 2'($urandom)};
        2:       adr = {4'h1, 18'($urandom_range(0, CW - 1)), 2'($urandom)};
        3, 4:    adr = {4'h2, 18'($urandom_range(0, VW - 1)), 2'($urandom)};
        5:       adr = {4'h3, ($urandom_range(0, 3) == 0) ? 18'($urandom_range(1, 9)) : 18'd0,
                        2'($urandom)};
        6:       adr = {4'($urandom_range(4, 15)), 18'($urandom), 2'($urandom)};
        default: begin
          w   = $urandom_range(0, 2);
          adr = {4'(w), 18'(((w == 2) ? VW : CW) + $urandom_range(0, 700)), 2'($urandom)};
        end
      endcase
      xfer(1'($urandom), adr, 4'($urandom), $urandom, got);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clock);
    end

    repeat (2) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
